hub75_scan_ctrl: RTL

Scan and binary-coded-modulation (BCM) scheduler for the HUB75 panel datapath. It decides which row, column and bit-plane the frame-buffer datapath reads, and generates the panel strobes: CLK_HUB75, LATCH, OE and ROWSEL. It shifts the next row/plane while the current one is displayed, scales on-time by a global brightness, and swaps frame buffers only at frame boundaries. It sits between the bus-mapped control register (enable, brightness, swap request) and the dual-buffer pixel RAM plus its comparators.

---
 rtl/hub75_scan_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: row/column/bit-plane scan and BCM scheduler for a HUB75 panel.
// Shifts row pair/plane N+1 while plane N is displayed, gates OE by a
// brightness-scaled share of each BCM window, and swaps frame buffers only
// at the end of a frame.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   enable              scan enable (sampled in IDLE and SHOW)
//   brightness          global brightness, sampled when a window starts
//   swap_req            one-cycle buffer swap request
//   rd_en/rd_row/rd_col/rd_plane  frame-buffer fetch strobe and address
//   buf_sel             active frame buffer
//   CLK_HUB75/LATCH/OE/ROWSEL     panel strobes (OE active low)
//   frame_done          one-cycle pulse at each frame boundary
module hub75_scan_ctrl #(
  parameter int ROWS       = 64,
  parameter int COLS       = 64,
  parameter int PWM_BITS   = 8,
  parameter int BASE_TICKS = 4,
  localparam int ADDRBITS  = $clog2(ROWS/2),
  localparam int COLBITS   = $clog2(COLS),
  localparam int PLBITS    = $clog2(PWM_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          brightness,
  input  logic                swap_req,
  output logic                rd_en,
  output logic [ADDRBITS-1:0] rd_row,
  output logic [COLBITS-1:0]  rd_col,
  output logic [PLBITS-1:0]   rd_plane,
  output logic                buf_sel,
  output logic                CLK_HUB75,
  output logic                LATCH,
  output logic                OE,
  output logic [ADDRBITS-1:0] ROWSEL,
  output logic                frame_done
);

  // Timer wide enough for the longest window BASE_TICKS<<(PWM_BITS-1).
  localparam int TW = $clog2(BASE_TICKS << (PWM_BITS-1)) + 1;

  typedef enum logic [2:0] {
    IDLE, S_ADDR, S_DATA, S_CLK, WAIT, BLANK, S_LATCH, SHOW
  } state_t;

  state_t state, state_nxt;

  logic [PLBITS-1:0] plane_shown;
  logic [TW-1:0]     tmr, tmr_nxt, win;
  // On-time counter kept at full product width so no bit of the scaled
  // window is dropped before the >>8.
  logic [TW+7:0]     on_left, on_nxt, prod;
  logic              swap_pend;
  logic              oe_nxt;
  logic              last_col, last_plane, last_row;

  assign last_col   = (rd_col   == COLBITS'(COLS-1));
  assign last_plane = (rd_plane == PLBITS'(PWM_BITS-1));
  assign last_row   = (rd_row   == ADDRBITS'(ROWS/2-1));

  assign win  = TW'(BASE_TICKS) << plane_shown;
  assign prod = {8'b0, win} * {{TW{1'b0}}, brightness};

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    on_nxt    = on_left;
    if (tmr != '0)     tmr_nxt = tmr - 1'b1;
    if (on_left != '0) on_nxt  = on_left - 1'b1;
    case (state)
      IDLE: begin
        // Nothing is displayed after IDLE until the first SHOW.
        tmr_nxt = '0;
        on_nxt  = '0;
        if (enable) state_nxt = S_ADDR;
      end
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  state_nxt = S_CLK;
      S_CLK:   state_nxt = last_col ? WAIT : S_ADDR;
      WAIT:    if (tmr == '0) state_nxt = BLANK;
      BLANK:   state_nxt = S_LATCH;
      S_LATCH: state_nxt = SHOW;
      SHOW: begin
        tmr_nxt   = win;
        on_nxt    = prod >> 8;
        state_nxt = enable ? S_ADDR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // on_left counts the remaining lit cycles, so OE is low exactly while
    // elapsed < on_ticks; BLANK and IDLE override it.
    oe_nxt = (state_nxt == IDLE) || (state_nxt == BLANK) || (on_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      on_left     <= '0;
      plane_shown <= '0;
      swap_pend   <= 1'b0;
      rd_en       <= 1'b0;
      rd_row      <= '0;
      rd_col      <= '0;
      rd_plane    <= '0;
      buf_sel     <= 1'b0;
      CLK_HUB75   <= 1'b0;
      LATCH       <= 1'b0;
      OE          <= 1'b1;
      ROWSEL      <= '0;
      frame_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tmr        <= tmr_nxt;
      on_left    <= on_nxt;
      rd_en      <= (state_nxt == S_ADDR);
      CLK_HUB75  <= (state_nxt == S_CLK);
      LATCH      <= (state_nxt == S_LATCH);
      OE         <= oe_nxt;
      frame_done <= 1'b0;
      if (swap_req) swap_pend <= 1'b1;

      if (state == IDLE && enable) begin
        rd_row   <= '0;
        rd_plane <= '0;
        rd_col   <= '0;
      end

      if (state == S_CLK) rd_col <= last_col ? '0 : rd_col + 1'b1;

      // Latch edge: publish the fetched row/plane, then advance plane-major.
      if (state == BLANK) begin
        ROWSEL      <= rd_row;
        plane_shown <= rd_plane;
        if (last_plane) begin
          rd_plane <= '0;
          rd_row   <= last_row ? '0 : rd_row + 1'b1;
        end else begin
          rd_plane <= rd_plane + 1'b1;
        end
        // A request sampled on this same edge is honoured at this boundary.
        if (last_plane && last_row) begin
          frame_done <= 1'b1;
          if (swap_pend || swap_req) begin
            buf_sel   <= ~buf_sel;
            swap_pend <= 1'b0;
          end
        end
      end
    end
  end

endmodule
